// File: rtl/store_pkg.sv
// store_pkg: shared encodings and helpers for the sub-word store controller.
//   size_e    : Bytes2Store encoding (none/byte/half/word)
//   state_e   : controller state encoding
//   misaligned: true when a store's size/offset combination cannot be issued
package store_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_e;

    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        return (sz == SZ_HALF && lo[0]) || (sz == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// store_lane_merge: combinational merge of store data into the old memory word.
//   old_word : word read from (or buffered for) the target address
//   reg_data : source register value
//   size     : store size (byte/half/word)
//   lane     : byte offset within the word (Address[1:0])
//   new_word : old_word with the addressed lane(s) replaced
module store_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] reg_data,
    input  size_e       size,
    input  logic [1:0]  lane,
    output logic [31:0] new_word
);

    logic [3:0]  be;
    logic [31:0] src;

    // Replicate the source so every lane already holds the right bytes;
    // the byte enables then choose which lanes take them.
    always_comb begin
        be  = size == SZ_BYTE ? 4'b0001 << lane :
              size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) :
              size == SZ_WORD ? 4'b1111 : 4'b0000;
        src = size == SZ_BYTE ? {4{reg_data[7:0]}} :
              size == SZ_HALF ? {2{reg_data[15:0]}} : reg_data;
    end

    genvar i;
    for (i = 0; i < 4; i++) begin : g_lane
        assign new_word[8*i +: 8] = be[i] ? src[8*i +: 8] : old_word[8*i +: 8];
    end

endmodule

// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: sequences sb/sh/sw stores to a single-port synchronous data
// memory; sw writes directly, sb/sh read-modify-write the containing word.
// Optional feature macro STORE_FWD_EN: one-entry last-write buffer that lets
// a sb/sh to the most recently written word skip the memory read.
//   Clk, Reset   : clock, asynchronous active-high reset
//   StoreReq     : store request, held with operands until Done
//   Address      : byte address; RegData: source value; Bytes2Store: 1/2/3 = sb/sh/sw
//   MemRdData    : memory read data, valid RD_LAT cycles after MemRdEn
//   MemAddr      : word-aligned memory address
//   MemRdEn/MemWrEn/MemWrData : memory strobes and merged write word
//   Stall        : hold pipeline; Done: completion pulse; AlignErr: misaligned pulse
module store_rmw_ctrl
    import store_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int AW     = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          StoreReq,
    input  logic [AW-1:0] Address,
    input  logic [31:0]   RegData,
    input  logic [1:0]    Bytes2Store,
    input  logic [31:0]   MemRdData,
    output logic [AW-1:0] MemAddr,
    output logic          MemRdEn,
    output logic          MemWrEn,
    output logic [31:0]   MemWrData,
    output logic          Stall,
    output logic          Done,
    output logic          AlignErr
);

    state_e        state;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    size_e         size_q;
    logic [2:0]    cnt;
    logic [31:0]   old_word;
    logic [31:0]   merged;
    logic          fwd_hit;
    size_e         req_size;
    logic          req;

    assign req_size = size_e'(Bytes2Store);
    assign req      = StoreReq && req_size != SZ_NONE;

`ifdef STORE_FWD_EN
    logic [AW-3:0] fwd_addr;
    logic [31:0]   fwd_data;
    logic          fwd_vld;
    logic          use_fwd;

    assign fwd_hit = fwd_vld && fwd_addr == Address[AW-1:2];

    // Every completed write refreshes the buffer, so it always mirrors memory.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fwd_addr <= '0;
            fwd_data <= '0;
            fwd_vld  <= 1'b0;
            use_fwd  <= 1'b0;
        end else begin
            if (state == IDLE && req)
                use_fwd <= fwd_hit;
            if (state == WRITE) begin
                fwd_addr <= addr_q[AW-1:2];
                fwd_data <= merged;
                fwd_vld  <= 1'b1;
            end
        end
    end

    assign old_word = use_fwd ? fwd_data : MemRdData;
`else
    assign fwd_hit  = 1'b0;
    assign old_word = MemRdData;
`endif

    // The memory presents read data during the WRITE cycle, so the merge
    // consumes MemRdData directly there instead of through an extra register.
    store_lane_merge u_merge (
        .old_word (old_word),
        .reg_data (data_q),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .new_word (merged)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            addr_q <= '0;
            data_q <= '0;
            size_q <= SZ_NONE;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    addr_q <= Address;
                    data_q <= RegData;
                    size_q <= req_size;
                    cnt    <= '0;
                    state  <= misaligned(req_size, Address[1:0]) ? ERR :
                              (req_size == SZ_WORD || fwd_hit) ? WRITE : READ;
                end
                READ:  state <= RD_LAT > 1 ? WAIT : WRITE;
                WAIT: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(RD_LAT - 2))
                        state <= WRITE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are decoded from state so an asynchronous reset kills them at once.
    assign MemAddr   = {addr_q[AW-1:2], 2'b00};
    assign MemRdEn   = state == READ;
    assign MemWrEn   = state == WRITE;
    assign MemWrData = MemWrEn ? merged : '0;
    assign Done      = state == WRITE || state == ERR;
    assign AlignErr  = state == ERR;
    assign Stall     = !Reset && (state == IDLE ? req : (state == READ || state == WAIT));

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// tb_store_rmw_ctrl: directed self-checking bench for store_rmw_ctrl with
// RD_LAT=1 and RD_LAT=3 instances, each behind its own synchronous memory model.
module tb_store_rmw_ctrl;

    localparam logic [31:0] INIT = 32'h0ACFFB19;
    localparam logic [31:0] REGV = 32'h0000FFAC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_req = 1'b1;
    logic        req1 = 1'b0, req3 = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  sz = 2'd0;
    logic        sel = 1'b0;

    logic [31:0] ma1, wd1, rdd1, ma3, wd3, rdd3;
    logic        rde1, wre1, st1, dn1, ae1, rde3, wre3, st3, dn3, ae3;

    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];
    logic [31:0] p1, p2;

    int checks = 0, failures = 0;
    int rd_tot = 0, wr_tot = 0, er_tot = 0, st_tot = 0, ov_tot = 0;
    logic [31:0] last_wd = '0, last_wa = '0, last_ra = '0;

    always #5 clk = ~clk;

    store_rmw_ctrl #(.RD_LAT(1), .AW(32)) dut1 (
        .Clk(clk), .Reset(rst), .StoreReq(req1), .Address(addr), .RegData(REGV),
        .Bytes2Store(sz), .MemRdData(rdd1), .MemAddr(ma1), .MemRdEn(rde1),
        .MemWrEn(wre1), .MemWrData(wd1), .Stall(st1), .Done(dn1), .AlignErr(ae1)
    );

    store_rmw_ctrl #(.RD_LAT(3), .AW(32)) dut3 (
        .Clk(clk), .Reset(rst), .StoreReq(req3), .Address(addr), .RegData(REGV),
        .Bytes2Store(sz), .MemRdData(rdd3), .MemAddr(ma3), .MemRdEn(rde3),
        .MemWrEn(wre3), .MemWrData(wd3), .Stall(st3), .Done(dn3), .AlignErr(ae3)
    );

    // Synchronous memories: latency 1 for dut1, a 3-stage read pipe for dut3.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= i == 4 ? INIT : 32'h0;
                mem3[i] <= i == 4 ? INIT : 32'h0;
            end
        end else begin
            if (wre1) mem1[ma1[5:2]] <= wd1;
            if (wre3) mem3[ma3[5:2]] <= wd3;
        end
        if (rde1) rdd1 <= mem1[ma1[5:2]];
        if (rde3) p1 <= mem3[ma3[5:2]];
        p2   <= p1;
        rdd3 <= p2;
    end

    logic [31:0] m_ma, m_wd;
    logic        m_rd, m_wr, m_st, m_dn, m_ae;
    assign m_ma = sel ? ma3 : ma1;
    assign m_wd = sel ? wd3 : wd1;
    assign m_rd = sel ? rde3 : rde1;
    assign m_wr = sel ? wre3 : wre1;
    assign m_st = sel ? st3 : st1;
    assign m_dn = sel ? dn3 : dn1;
    assign m_ae = sel ? ae3 : ae1;

    always @(negedge clk) begin
        if (m_rd) begin rd_tot++; last_ra = m_ma; end
        if (m_wr) begin wr_tot++; last_wd = m_wd; last_wa = m_ma; end
        if (m_ae) er_tot++;
        if (m_st) st_tot++;
        if (m_rd && m_wr) ov_tot++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic reinit();
        rst = 1'b1;
        init_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        init_req = 1'b0;
    endtask

    task automatic store(input logic s, input logic [1:0] z, input logic [31:0] a,
                         input int exp_lat, input int exp_rd, input logic exp_err,
                         input logic [31:0] exp_wd, input logic [31:0] exp_mem,
                         input string tag);
        int lat, rd0, wr0, er0, st0, ov0;
        logic seen;
        sel = s;
        @(posedge clk);
        #2;
        rd0 = rd_tot; wr0 = wr_tot; er0 = er_tot; st0 = st_tot; ov0 = ov_tot;
        addr = a;
        sz = z;
        if (s) req3 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            @(negedge clk);
            lat++;
            seen = m_dn;
        end
        req1 = 1'b0;
        req3 = 1'b0;
        sz = 2'd0;
        @(posedge clk);
        #1;
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".rd"}, rd_tot - rd0, exp_rd);
        chk({tag, ".wr"}, wr_tot - wr0, exp_err ? 0 : 1);
        chk({tag, ".err"}, er_tot - er0, exp_err ? 1 : 0);
        chk({tag, ".stall"}, st_tot - st0, exp_lat);
        chk({tag, ".ovl"}, ov_tot - ov0, 0);
        if (!exp_err) begin
            chk({tag, ".wd"}, last_wd, exp_wd);
            chk({tag, ".wa"}, last_wa, {a[31:2], 2'b00});
        end
        if (exp_rd != 0) chk({tag, ".ra"}, last_ra, {a[31:2], 2'b00});
        chk({tag, ".mem"}, s ? mem3[4] : mem1[4], exp_mem);
    endtask

    initial begin
        int w0, r0;
        // Stall must stay low while reset is asserted even with a request present
        req1 = 1'b1;
        sz = 2'd3;
        #3;
        chk("rst.stall", st1, 0);
        req1 = 1'b0;
        sz = 2'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        init_req = 1'b0;
        #1;
        chk("rst.addr", ma1, 0);
        chk("rst.wd", wd1, 0);
        chk("rst.done", dn1, 0);
        chk("rst.strobes", {rde1, wre1, ae1, st1}, 0);

        // Bytes2Store=0 is ignored
        w0 = wr_tot; r0 = rd_tot;
        req1 = 1'b1;
        sz = 2'd0;
        addr = 32'h10;
        #1;
        chk("none.stall", st1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("none.acts", (wr_tot - w0) + (rd_tot - r0), 0);
        chk("none.done", dn1, 0);
        req1 = 1'b0;

        reinit(); store(0, 2'd3, 32'h10, 1, 0, 0, 32'h0000FFAC, 32'h0000FFAC, "sw10");
        reinit(); store(0, 2'd1, 32'h11, 2, 1, 0, 32'h0ACFAC19, 32'h0ACFAC19, "sb11");
        reinit(); store(0, 2'd1, 32'h13, 2, 1, 0, 32'hACCFFB19, 32'hACCFFB19, "sb13");
        reinit(); store(0, 2'd2, 32'h12, 2, 1, 0, 32'hFFACFB19, 32'hFFACFB19, "sh12");
        reinit(); store(0, 2'd2, 32'h10, 2, 1, 0, 32'h0ACFFFAC, 32'h0ACFFFAC, "sh10");
        reinit(); store(0, 2'd2, 32'h11, 1, 0, 1, 32'h0, INIT, "sh11");
        store(0, 2'd3, 32'h12, 1, 0, 1, 32'h0, INIT, "sw12");

        // RD_LAT=3: reset lands in WAIT, write must be aborted
        reinit();
        sel = 1'b1;
        w0 = wr_tot;
        @(posedge clk);
        #2;
        addr = 32'h10;
        sz = 2'd1;
        req3 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("abort.inwait", st3, 1);
        rst = 1'b1;
        #1;
        chk("abort.wr", wre3, 0);
        chk("abort.rd", rde3, 0);
        chk("abort.stall", st3, 0);
        chk("abort.done", {dn3, ae3}, 0);
        chk("abort.addr", ma3, 0);
        chk("abort.wd", wd3, 0);
        req3 = 1'b0;
        sz = 2'd0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort.nowrite", wr_tot - w0, 0);
        chk("abort.mem", mem3[4], INIT);
        store(1, 2'd1, 32'h10, 4, 1, 0, 32'h0ACFFBAC, 32'h0ACFFBAC, "sb10l3");

`ifdef STORE_FWD_EN
        reinit();
        store(0, 2'd3, 32'h10, 1, 0, 0, 32'h0000FFAC, 32'h0000FFAC, "fwd.sw");
        store(0, 2'd1, 32'h12, 1, 0, 0, 32'h00ACFFAC, 32'h00ACFFAC, "fwd.sb");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
